// File: rtl/de_emph_filter_if.sv
// Sample-stream bundle between the voice core, the de-emphasis filter and the I2S transmitter.
// With DE_EMPH_BYPASS_EN defined the bundle also carries the bypass control.
interface de_emph_filter_if #(
  parameter int unsigned DATA_WIDTH = 16
);

  logic                         clr;
  logic signed [DATA_WIDTH-1:0] data;
  logic                         l_vld;
  logic                         r_vld;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic                         out_l_vld;
  logic                         out_r_vld;
  logic                         drop_err;
`ifdef DE_EMPH_BYPASS_EN
  logic                         bypass;
`endif

`ifdef DE_EMPH_BYPASS_EN
  modport master (
    output clr, data, l_vld, r_vld, bypass,
    input  in_ready, data_out, out_l_vld, out_r_vld, drop_err
  );

  modport slave (
    input  clr, data, l_vld, r_vld, bypass,
    output in_ready, data_out, out_l_vld, out_r_vld, drop_err
  );
`else
  modport master (
    output clr, data, l_vld, r_vld,
    input  in_ready, data_out, out_l_vld, out_r_vld, drop_err
  );

  modport slave (
    input  clr, data, l_vld, r_vld,
    output in_ready, data_out, out_l_vld, out_r_vld, drop_err
  );
`endif

endinterface

// File: rtl/de_emph_filter.sv
// Stereo first-order de-emphasis y = x + a*y[n-1] with one shared multiplier and a 1-entry
// pending buffer. Optional bypass input enabled by defining DE_EMPH_BYPASS_EN.
module de_emph_filter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned COEF       = 32113
) (
  input  logic              sck,
  input  logic              rst,
  de_emph_filter_if.slave   bus
);

  localparam int unsigned PW = DATA_WIDTH + COEF_WIDTH + 1;
  localparam int unsigned SW = DATA_WIDTH + 2;

  localparam logic signed [SW-1:0] SatMax = SW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] SatMin = ~SatMax;
  localparam logic signed [PW-1:0] RndOfs = PW'(2 ** (COEF_WIDTH - 2));
  localparam logic signed [PW-1:0] CoefExt = PW'(COEF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ADD
  } state_e;

  state_e                       r_state;
  state_e                       w_state_d;

  // Operand latched for the sample in flight; r_ch = 1 means right channel.
  logic signed [DATA_WIDTH-1:0] r_x;
  logic                         r_ch;

  logic                         r_pend_full;
  logic signed [DATA_WIDTH-1:0] r_pend_x;
  logic                         r_pend_ch;

  logic signed [PW-1:0]         r_prod;
  logic signed [DATA_WIDTH-1:0] r_y_l;
  logic signed [DATA_WIDTH-1:0] r_y_r;

  logic signed [DATA_WIDTH-1:0] r_data_out;
  logic                         r_out_l_vld;
  logic                         r_out_r_vld;
  logic                         r_drop_err;

  logic                         w_take;
  logic                         w_take_ch;
  logic                         w_push;
  logic                         w_push_ch;
  logic                         w_drop;

  logic                         w_ld;
  logic signed [DATA_WIDTH-1:0] w_ld_x;
  logic                         w_ld_ch;
  logic                         w_pop;
  logic                         w_emit;

  logic signed [DATA_WIDTH-1:0] w_y_sel;
  logic signed [PW-1:0]         w_y_ext;
  logic signed [PW-1:0]         w_prod;
  logic signed [PW-1:0]         w_prod_rnd;
  logic signed [SW-1:0]         w_fb;
  logic signed [SW-1:0]         w_sum;
  logic signed [DATA_WIDTH-1:0] w_sat;
  logic signed [DATA_WIDTH-1:0] w_res;

  // Strobe steering: IDLE takes a strobe straight into the datapath, a busy FSM parks it in
  // pending. A simultaneous pair always gives left priority.
  always_comb begin
    w_take    = 1'b0;
    w_take_ch = 1'b0;
    w_push    = 1'b0;
    w_push_ch = 1'b0;
    w_drop    = 1'b0;
    if (r_pend_full) begin
      w_drop = bus.l_vld | bus.r_vld;
    end else if (r_state == S_IDLE) begin
      w_take    = bus.l_vld | bus.r_vld;
      w_take_ch = ~bus.l_vld;
      w_push    = bus.l_vld & bus.r_vld;
      w_push_ch = 1'b1;
    end else begin
      w_push    = bus.l_vld | bus.r_vld;
      w_push_ch = ~bus.l_vld;
      w_drop    = bus.l_vld & bus.r_vld;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_ld      = 1'b0;
    w_ld_x    = r_x;
    w_ld_ch   = r_ch;
    w_pop     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_pend_full) begin
          w_pop     = 1'b1;
          w_ld      = 1'b1;
          w_ld_x    = r_pend_x;
          w_ld_ch   = r_pend_ch;
          w_state_d = S_MUL;
        end else if (w_take) begin
          w_ld      = 1'b1;
          w_ld_x    = bus.data;
          w_ld_ch   = w_take_ch;
          w_state_d = S_MUL;
        end
      end
      S_MUL: begin
        w_state_d = S_ADD;
      end
      S_ADD: begin
        if (r_pend_full) begin
          w_pop     = 1'b1;
          w_ld      = 1'b1;
          w_ld_x    = r_pend_x;
          w_ld_ch   = r_pend_ch;
          w_state_d = S_MUL;
        end else begin
          w_state_d = S_IDLE;
        end
      end
      default: begin
        w_state_d = S_IDLE;
      end
    endcase
  end

  assign w_emit = (r_state == S_ADD);

  // Datapath: signed y times zero-extended coefficient, then round-half-up back to Q0.
  assign w_y_sel    = r_ch ? r_y_r : r_y_l;
  assign w_y_ext    = PW'(w_y_sel);
  assign w_prod     = w_y_ext * CoefExt;
  assign w_prod_rnd = r_prod + RndOfs;
  assign w_fb       = SW'(w_prod_rnd >>> (COEF_WIDTH - 1));
  assign w_sum      = SW'(r_x) + w_fb;

  always_comb begin
    if (w_sum > SatMax) begin
      w_sat = SatMax[DATA_WIDTH-1:0];
    end else if (w_sum < SatMin) begin
      w_sat = SatMin[DATA_WIDTH-1:0];
    end else begin
      w_sat = w_sum[DATA_WIDTH-1:0];
    end
  end

`ifdef DE_EMPH_BYPASS_EN
  // Bypass also reloads the channel state with x so re-enabling the filter does not glitch.
  assign w_res = bus.bypass ? r_x : w_sat;
`else
  assign w_res = w_sat;
`endif

  always_ff @(posedge sck) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_ch        <= 1'b0;
      r_pend_full <= 1'b0;
      r_pend_x    <= '0;
      r_pend_ch   <= 1'b0;
      r_prod      <= '0;
      r_y_l       <= '0;
      r_y_r       <= '0;
      r_data_out  <= '0;
      r_out_l_vld <= 1'b0;
      r_out_r_vld <= 1'b0;
      r_drop_err  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pend_full <= (r_pend_full & ~w_pop) | w_push;
      r_out_l_vld <= w_emit & ~r_ch;
      r_out_r_vld <= w_emit & r_ch;
      if (w_ld) begin
        r_x  <= w_ld_x;
        r_ch <= w_ld_ch;
      end
      if (w_push) begin
        r_pend_x  <= bus.data;
        r_pend_ch <= w_push_ch;
      end
      if (r_state == S_MUL) begin
        r_prod <= w_prod;
      end
      if (w_emit) begin
        r_data_out <= w_res;
      end
      if (w_drop) begin
        r_drop_err <= 1'b1;
      end
      // clr beats the state write-back but the computed sample still goes out.
      if (bus.clr) begin
        r_y_l <= '0;
        r_y_r <= '0;
      end else if (w_emit) begin
        if (r_ch) begin
          r_y_r <= w_res;
        end else begin
          r_y_l <= w_res;
        end
      end
    end
  end

  assign bus.in_ready  = ~r_pend_full;
  assign bus.data_out  = r_data_out;
  assign bus.out_l_vld = r_out_l_vld;
  assign bus.out_r_vld = r_out_r_vld;
  assign bus.drop_err  = r_drop_err;

endmodule
